// File: rtl/fifo_fwft_out.sv
// -----------------------------------------------------------------------------
// fifo_fwft_out
//
// Read-side output stage that sits directly behind the async FIFO read
// wrapper, in the read clock domain. It issues reads whenever the FIFO is not
// empty and there is room for the result. It captures the RAM output one
// cycle after each read. It then presents the words to the consumer as
// first-word-fall-through data on a valid/ready handshake.
//
// A 3-entry buffer with credit accounting (occupied entries + word in flight)
// sustains one word per clock. The read enable depends only on registers and
// the FIFO empty flag, so there is no combinational path from i_ready to
// o_fifo_rd_en.
//
// Ports:
//   clk            read-domain clock
//   reset_async_n  asynchronous reset, active low (deasserted via 2-flop sync)
//   i_fifo_empty   FIFO empty flag from the read wrapper
//   o_fifo_rd_en   FIFO read enable to the read wrapper
//   iv_fifo_dout   RAM read data, valid the cycle after o_fifo_rd_en=1
//   o_valid        ov_data holds a valid word
//   i_ready        consumer accepts the word this cycle
//   ov_data        head-of-buffer word (holds last value when o_valid=0)
//   ov_buf_cnt     number of occupied buffer entries (0..3), for debug
// -----------------------------------------------------------------------------
module fifo_fwft_out #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset_async_n,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] iv_fifo_dout,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic [1:0]            ov_buf_cnt
);

    // The credit arithmetic and the 2-bit occupancy port only work for
    // exactly three entries.
    if (BUF_DEPTH != 3) begin : g_bad_depth
        $error("fifo_fwft_out: BUF_DEPTH must be exactly 3");
    end

    // -------------------------------------------------------------------------
    // Reset synchronizer: asserts immediately and releases two edges later.
    // -------------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       reset_sync;

    always_ff @(posedge clk or negedge reset_async_n) begin
        if (!reset_async_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign reset_sync = ~sync_reg[1];

    // -------------------------------------------------------------------------
    // Buffer state
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] buf_reg   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_next  [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] shift_src [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  wr_here;
    logic [BUF_DEPTH-1:0]  shift_here;

    logic [1:0] buf_cnt_reg;
    logic [1:0] buf_cnt_next;
    logic       inflight_reg;
    logic       valid_reg;
    logic       valid_next;

    logic       capture;
    logic       pop;
    logic [2:0] cnt_w;
    logic [2:0] credit;
    logic [2:0] cnt_sum;

    assign cnt_w  = {1'b0, buf_cnt_reg};
    assign credit = cnt_w + {2'b00, inflight_reg};

    // Credit only counts what is already committed (stored + in flight). A pop
    // this cycle frees a slot that is only reused next cycle. That costs
    // nothing at steady state, because buf_cnt=1 and inflight=1 still leave
    // one free credit.
    assign o_fifo_rd_en = ~reset_sync & ~i_fifo_empty & (credit < 3'd3);

    // A word read last cycle is on iv_fifo_dout now. It is always captured;
    // credit guarantees a free slot for it.
    assign capture = inflight_reg;
    assign pop     = valid_reg & i_ready;

    // 3 bits wide so that an impossible over/underflow remains observable.
    assign cnt_sum      = cnt_w + {2'b00, capture} - {2'b00, pop};
    assign buf_cnt_next = cnt_sum[1:0];
    assign valid_next   = (cnt_sum != 3'd0);

    // -------------------------------------------------------------------------
    // Per-entry next-state. Entry 0 is the head. On a pop every occupied entry
    // shifts down by one. A capture lands at the first free slot, measured
    // after the shift. Entries that are neither shifted nor written keep their
    // value. This lets the head keep its last word after the buffer drains.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        localparam logic [2:0] IDX = 3'(gi);

        if (gi < BUF_DEPTH - 1) begin : g_mid
            assign shift_src[gi] = buf_reg[gi+1];
        end else begin : g_last
            // The last entry never has an occupied neighbour above it.
            assign shift_src[gi] = buf_reg[gi];
        end

        assign wr_here[gi]    = capture && ((pop ? (IDX + 3'd1) : IDX) == cnt_w);
        assign shift_here[gi] = pop && ((IDX + 3'd1) < cnt_w);
        assign buf_next[gi]   = wr_here[gi]    ? iv_fifo_dout  :
                                shift_here[gi] ? shift_src[gi] :
                                                 buf_reg[gi];
    end

    // -------------------------------------------------------------------------
    // State registers. Everything clears asynchronously. While the
    // synchronizer holds reset, no read is issued, so nothing is ever
    // captured or popped, and the state stays cleared.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_async_n) begin
        if (!reset_async_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_reg[i] <= '0;
            end
            buf_cnt_reg  <= 2'd0;
            inflight_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_reg[i] <= buf_next[i];
            end
            buf_cnt_reg  <= buf_cnt_next;
            inflight_reg <= o_fifo_rd_en;
            valid_reg    <= valid_next;
        end
    end

    assign o_valid    = valid_reg;
    assign ov_data    = buf_reg[0];
    assign ov_buf_cnt = buf_cnt_reg;

    // -------------------------------------------------------------------------
    // Safety checks: occupancy never leaves 0..3, and a capture never meets a
    // full buffer without a simultaneous pop.
    // -------------------------------------------------------------------------
    a_cnt_range: assert property (@(posedge clk) disable iff (!reset_async_n)
        cnt_sum <= 3'd3);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_async_n)
        !(capture && (buf_cnt_reg == 2'd3) && !pop));

endmodule

// File: doc/fifo_fwft_out.md
Name: fifo_fwft_out

Overview:
- Read-side output stage placed directly downstream of the async FIFO read wrapper, in the read clock domain.
- Drives the wrapper's read enable from its empty flag and captures the dual-port RAM output, which arrives one cycle after the read.
- Presents the words to the consumer as first-word-fall-through data on a valid/ready handshake.
- Contains a 3-entry credit-managed output buffer, so it sustains one word per clock with no combinational path from i_ready to o_fifo_rd_en.

Parameters:
- DATA_WIDTH, 8, width of the FIFO data word.
- BUF_DEPTH, 3, number of output buffer entries. Fixed at 3; any other value is illegal and the implementation must fail elaboration.

Ports:
- clk  input  1  read-domain clock.
- reset_async_n  input  1  asynchronous reset, active low.
- i_fifo_empty  input  1  FIFO empty flag from the read wrapper.
- o_fifo_rd_en  output  1  FIFO read enable to the read wrapper.
- iv_fifo_dout  input  DATA_WIDTH  RAM read data; valid in the cycle after o_fifo_rd_en=1.
- o_valid  output  1  ov_data holds a valid word.
- i_ready  input  1  consumer accepts the word this cycle.
- ov_data  output  DATA_WIDTH  head-of-buffer word.
- ov_buf_cnt  output  2  number of occupied buffer entries (0..3), for debug.

Behaviour:
- Reset:
  - reset_async_n is asserted asynchronously and deasserted through an internal 2-flop synchronizer (reset_sync).
  - While reset_sync is active: o_valid=0, ov_data=0, ov_buf_cnt=0, in-flight flag=0, o_fifo_rd_en=0.
  - o_fifo_rd_en is gated by reset_sync so that no read is issued during reset.
- Credit:
  - credit = buf_cnt + inflight, where inflight is a register equal to o_fifo_rd_en delayed by one cycle.
  - o_fifo_rd_en = !reset_sync && !i_fifo_empty && (credit < 3).
  - o_fifo_rd_en is combinational from registers and i_fifo_empty only.
- Capture:
  - When inflight=1, iv_fifo_dout is written at the tail of the buffer on that clock edge.
  - The write is unconditional; the credit rule guarantees a free slot.
- Pop: pop = o_valid && i_ready. On pop the head is removed and the next entry becomes the head on the following cycle.
- Occupancy and outputs:
  - Simultaneous capture and pop leaves buf_cnt unchanged and preserves order.
  - Capture into an empty buffer makes the word the head directly.
  - o_valid = (buf_cnt != 0). It is registered and glitch-free.
  - ov_data is stable while o_valid=1 and i_ready=0.
  - ov_data holds its last value when o_valid=0; it is not zeroed.
- Latency: i_fifo_empty falls in cycle N → o_fifo_rd_en=1 in cycle N → word captured at the end of N+1 → o_valid=1 in cycle N+2.
- Throughput: in steady state buf_cnt=1 and inflight=1, with one read, one capture and one pop per cycle.
- Backpressure:
  - With i_ready held at 0, at most 3 words are read, then o_fifo_rd_en stays at 0.
  - When i_ready rises, reads restart in the same cycle that credit drops below 3 (one cycle after the pop).
- Empty:
  - i_fifo_empty=1 blocks reads.
  - A word already in flight is still captured.
  - The buffer drains normally.
- Ordering: output order is identical to read order, with no loss or duplication under any ready/empty pattern.
- Errors: overflow and underflow are impossible by construction. Assertions must flag buf_cnt>3, and capture while buf_cnt=3 with no pop.
- Reset mid-operation: the buffer and in-flight word are discarded, and the outputs return to their reset values asynchronously.

Test Plan:
- Reset, then present FIFO words 0x11, 0x22, 0x33 with i_ready=1: o_fifo_rd_en in cycles 0, 1, 2; o_valid=1 from cycle 2; ov_data=0x11, 0x22, 0x33 in consecutive cycles.
- i_ready=0 and FIFO holding 5 words: exactly 3 reads, ov_buf_cnt=3, o_fifo_rd_en=0 thereafter. Then raise i_ready: all 5 words delivered in order with no gap after the first.
- Continuous stream of 64 incrementing words with i_ready=1: 64 reads and 64 pops; after the initial 2-cycle latency, o_valid is never 0 while the FIFO is non-empty.
- Random i_ready (50%) and random i_fifo_empty over 10000 words: scoreboard shows in-order and lossless delivery; the overflow/underflow assertions never fire.
- i_fifo_empty rises the cycle after a single read: the in-flight word is captured, o_valid pulses for one beat with i_ready=1, and o_fifo_rd_en stays at 0.
- Assert reset_async_n low while ov_buf_cnt=2 and inflight=1: o_valid=0, ov_buf_cnt=0 and o_fifo_rd_en=0 immediately. After release, no read until the 2-cycle synchronizer delay has elapsed, and no stale word is ever output.
